// File: rtl/line_doubler_2x.sv
// 2x nearest-neighbour line doubler.
// Input lines are written ping-pong into two line RAMs. Each stored line is
// replayed twice (vertical 2x) and every pixel is emitted twice (horizontal 2x).
// A bank is only freed once both replays have drained, which is where input
// backpressure comes from.

// Line RAM: synchronous write, combinational read while selected for read.
module single_port_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  i_cs,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Storage is never cleared; only whole written lines are ever read back.
  always_ff @(posedge clk) begin
    if (i_cs && i_we) mem[i_addr] <= i_din;
  end

  assign o_dout = (i_cs && !i_we) ? mem[i_addr] : '0;
endmodule

module line_doubler_2x #(
  parameter int H_PIX      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_eol
);
  // rd_x walks the doubled line, so it needs one bit more than a RAM address.
  localparam int XW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] WR_LAST = ADDR_WIDTH'(H_PIX - 1);
  localparam logic [XW-1:0]         RD_LAST = XW'(2 * H_PIX - 1);

  logic [1:0]            bank_full;
  logic                  wr_sel, rd_sel;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [XW-1:0]         rd_x;
  logic                  rd_rep;

  logic in_acc, out_acc, wr_last, rd_last;
  logic [1:0] full_set, full_clr;

  logic [1:0]                 bank_cs, bank_we;
  logic [1:0][ADDR_WIDTH-1:0] bank_addr;
  logic [1:0][DATA_WIDTH-1:0] bank_din, bank_dout;

  // Flags are register-only, so a bank freed by the reader shows up on
  // o_ready one cycle later, never combinationally.
  assign o_ready = !reset && !bank_full[wr_sel];
  assign o_valid = !reset && bank_full[rd_sel];
  assign in_acc  = i_valid && o_ready;
  assign out_acc = o_valid && i_ready;
  assign wr_last = (wr_addr == WR_LAST);
  assign rd_last = (rd_x == RD_LAST);

  assign o_data = o_valid ? bank_dout[rd_sel] : '0;
  assign o_eol  = o_valid && rd_last;

  // A write needs an empty bank and a read needs a full one, so the two
  // ports can never land on the same bank in one cycle.
  genvar b;
  for (b = 0; b < 2; b++) begin : g_bank
    logic wr_hit, rd_hit;
    assign wr_hit       = in_acc  && (wr_sel == 1'(b));
    assign rd_hit       = o_valid && (rd_sel == 1'(b));
    assign bank_cs[b]   = wr_hit || rd_hit;
    assign bank_we[b]   = wr_hit;
    assign bank_addr[b] = wr_hit ? wr_addr : rd_x[XW-1:1];
    assign bank_din[b]  = i_data;
    assign full_set[b]  = wr_hit && wr_last;
    assign full_clr[b]  = out_acc && rd_last && rd_rep && (rd_sel == 1'(b));

    single_port_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
      .clk    (clk),
      .i_cs   (bank_cs[b]),
      .i_we   (bank_we[b]),
      .i_addr (bank_addr[b]),
      .i_din  (bank_din[b]),
      .o_dout (bank_dout[b])
    );
  end

  // Write/read pointers advance independently; per-bank set/clear never
  // collide because a bank being cleared is full and cannot be written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_full <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_addr   <= '0;
      rd_x      <= '0;
      rd_rep    <= 1'b0;
    end else begin
      bank_full <= (bank_full | full_set) & ~full_clr;
      if (in_acc) begin
        if (wr_last) begin
          wr_addr <= '0;
          wr_sel  <= ~wr_sel;
        end else begin
          wr_addr <= wr_addr + ADDR_WIDTH'(1);
        end
      end
      if (out_acc) begin
        if (rd_last) begin
          rd_x   <= '0;
          rd_rep <= ~rd_rep;
          if (rd_rep) rd_sel <= ~rd_sel;
        end else begin
          rd_x <= rd_x + XW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_line_doubler_2x.sv
// Directed bench for line_doubler_2x with H_PIX=4 and a queue-based model of
// the doubled output stream, checked on every falling edge.
module tb_line_doubler_2x;
  localparam int H  = 4;
  localparam int AW = 6;
  localparam int DW = 30;
  typedef logic [DW-1:0] pix_t;

  logic clk = 0, reset = 1;
  pix_t i_data = '0;
  logic i_valid = 0, i_ready = 0;
  logic o_ready, o_valid, o_eol;
  pix_t o_data;

  line_doubler_2x #(.H_PIX(H), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_eol(o_eol)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: complete stored lines in pix_q (oldest first), the line being
  // written in part_q, and position within the current 4*H output beats.
  pix_t pix_q[$];
  pix_t part_q[$];
  int   out_pos = 0;

  function automatic bit m_valid();
    return !reset && pix_q.size() >= H;
  endfunction
  function automatic bit m_ready();
    return !reset && pix_q.size() < 2 * H;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q.delete();
      part_q.delete();
      out_pos = 0;
    end else begin
      bit ia, oa;
      ia = i_valid && m_ready();
      oa = m_valid() && i_ready;
      if (oa) begin
        if (out_pos == 4 * H - 1) begin
          repeat (H) void'(pix_q.pop_front());
          out_pos = 0;
        end else out_pos++;
      end
      if (ia) begin
        part_q.push_back(i_data);
        if (part_q.size() == H) begin
          foreach (part_q[k]) pix_q.push_back(part_q[k]);
          part_q.delete();
        end
      end
    end
  end

  // Output log and stall-hold tracking.
  pix_t dut_log[$];
  bit   eol_log[$];
  bit   prev_stall = 0;
  pix_t prev_data;
  logic prev_eol;

  always @(negedge clk) begin
    bit ev;
    int ph;
    ev = m_valid();
    chk("o_valid", o_valid, ev);
    chk("o_ready", o_ready, m_ready());
    if (ev) begin
      ph = out_pos % (2 * H);
      chk("o_data", o_data, pix_q[ph / 2]);
      chk("o_eol", o_eol, ph == 2 * H - 1);
    end else begin
      chk("o_data_idle", o_data, 0);
      chk("o_eol_idle", o_eol, 0);
    end
    for (int b = 0; b < 2; b++)
      chk("bank_excl", dut.bank_cs[b] && dut.bank_we[b] && o_valid && (dut.rd_sel == 1'(b)), 0);
    if (prev_stall && o_valid && !reset) begin
      chk("hold_data", o_data, prev_data);
      chk("hold_eol", o_eol, prev_eol);
    end
    prev_stall = o_valid && !i_ready && !reset;
    prev_data  = o_data;
    prev_eol   = o_eol;
    if (o_valid && i_ready) begin
      dut_log.push_back(o_data);
      eol_log.push_back(o_eol);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel until accepted; returns the number of stalled cycles.
  task automatic send_pixel(input pix_t d, output int stalls);
    bit acc;
    stalls = 0;
    i_valid = 1;
    i_data  = d;
    do begin
      acc = o_ready;
      cyc();
      if (!acc) stalls++;
    end while (!acc && stalls < 200);
    if (!acc) chk("send_timeout", 1, 0);
    i_valid = 0;
  endtask

  task automatic send_line(input pix_t base);
    int s;
    for (int i = 0; i < H; i++) send_pixel(base + pix_t'(i), s);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  function automatic void dbl(inout pix_t q[$], input pix_t base);
    for (int r = 0; r < 2; r++)
      for (int x = 0; x < 2 * H; x++) q.push_back(base + pix_t'(x / 2));
  endfunction

  task automatic check_log(input string name, input pix_t exp[$]);
    chk({name, "_len"}, dut_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dut_log.size(); i++) begin
      chk({name, "_data"}, dut_log[i], exp[i]);
      chk({name, "_eol"}, eol_log[i], (i % (2 * H)) == 2 * H - 1);
    end
    dut_log.delete();
    eol_log.delete();
  endtask

  initial begin
    pix_t exp[$];
    int s, first_block, block_stalls, n;

    // Reset state
    #2;
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", o_valid, 0);
    #10 reset = 0;
    cyc();
    chk("post_rst_ready", o_ready, 1);
    chk("post_rst_valid", o_valid, 0);
    dut_log.delete(); eol_log.delete();

    // Test 1: single line 1..4, latency and literal output
    i_ready = 1;
    for (int i = 1; i <= 3; i++) send_pixel(pix_t'(i), s);
    chk("t1_valid_before", o_valid, 0);
    send_pixel(pix_t'(4), s);
    chk("t1_valid_after", o_valid, 1);
    chk("t1_first_data", o_data, 1);
    idle(20);
    exp = '{1,1,2,2,3,3,4,4,1,1,2,2,3,3,4,4};
    check_log("t1", exp);

    // Test 2: back-to-back lines A, B, C
    first_block = -1; block_stalls = 0; n = 0;
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < H; i++) begin
        send_pixel(pix_t'(10 * (l + 1) + i), s);
        if (s > 0 && first_block < 0) begin
          first_block = n;
          block_stalls = s;
        end
        n++;
      end
    chk("t2_accepts_before_block", first_block, 8);
    chk("t2_block_len", block_stalls, 12);
    idle(60);
    exp.delete(); dbl(exp, 10); dbl(exp, 20); dbl(exp, 30);
    check_log("t2", exp);

    // Test 3: readout with i_ready pattern 1,0,0,1
    i_ready = 0;
    send_line(40);
    for (int k = 0; k < 40; k++) begin
      i_ready = (k % 4 == 0) || (k % 4 == 3);
      cyc();
    end
    i_ready = 1;
    idle(20);
    exp.delete(); dbl(exp, 40);
    check_log("t3", exp);

    // Test 4: B's last write on the same edge as A's last output
    i_ready = 0;
    send_line(50);
    for (int i = 0; i < H - 1; i++) send_pixel(pix_t'(60 + i), s);
    i_ready = 1;
    idle(15);
    i_valid = 1; i_data = 63;
    cyc();
    i_valid = 0;
    chk("t4_valid", o_valid, 1);
    chk("t4_ready", o_ready, 1);
    chk("t4_data", o_data, 60);
    chk("t4_full_count", $countones(dut.bank_full), 1);
    idle(20);
    exp.delete(); dbl(exp, 50); dbl(exp, 60);
    check_log("t4", exp);

    // Test 5: asynchronous reset mid-readout with a partial line pending
    send_line(70);
    send_pixel(80, s);
    send_pixel(81, s);
    idle(3);
    #3 reset = 1;
    #1;
    chk("t5_rst_valid", o_valid, 0);
    chk("t5_rst_ready", o_ready, 0);
    cyc();
    #3 reset = 0;
    cyc();
    chk("t5_post_ready", o_ready, 1);
    chk("t5_post_valid", o_valid, 0);
    dut_log.delete(); eol_log.delete();
    send_line(90);
    idle(20);
    exp.delete(); dbl(exp, 90);
    check_log("t5", exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
